rr_arbiter8: RTL and testbench

- Eight-requester round-robin arbiter with a bounded grant hold time. Shares one downstream resource (bus slot, encoder/datapath port) between eight clients.
- Complements the combinational fixed-priority encoder: this block rotates priority so no requester starves.
- Grants are registered and one-hot. They come with a binary grant index and a valid flag, in the same {valid, code} style as the encoder outputs.

---
 rtl/rr_arbiter8.sv | 101 ++++++++++
 tb/tb_rr_arbiter8.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with a bounded grant hold time.
// Registered one-hot grant plus {valid, index}; priority rotates past each released owner.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic [2:0] gnt_id
);

  localparam int unsigned N = 8;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e           state_q;
  logic [2:0]       ptr_q;
  logic [CNT_W-1:0] hold_cnt_q;

  logic       release_c;
  logic [2:0] base_c;
  logic [2:0] cand_c;
  logic [2:0] win_c;
  logic       found_c;

  // On release the search starts just past the owner, otherwise at ptr.
  always_comb begin
    release_c = (state_q == GRANT) && (!req[gnt_id] || (hold_cnt_q == HOLD_LAST));
    base_c    = (state_q == GRANT) ? (gnt_id + 3'd1) : ptr_q;
    found_c   = 1'b0;
    win_c     = 3'd0;
    cand_c    = 3'd0;
    // Scan from farthest to nearest so the nearest set bit wins.
    for (int k = N - 1; k >= 0; k--) begin
      cand_c = base_c + 3'(k);
      if (req[cand_c]) begin
        found_c = 1'b1;
        win_c   = cand_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd0;
      hold_cnt_q <= '0;
      gnt        <= 8'd0;
      gnt_valid  <= 1'b0;
      gnt_id     <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en && found_c) begin
            state_q    <= GRANT;
            hold_cnt_q <= '0;
            gnt        <= 8'd1 << win_c;
            gnt_valid  <= 1'b1;
            gnt_id     <= win_c;
          end else begin
            gnt       <= 8'd0;
            gnt_valid <= 1'b0;
            gnt_id    <= 3'd0;
          end
        end
        GRANT: begin
          if (!release_c) begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end else begin
            ptr_q <= gnt_id + 3'd1;
            // Hand off with no idle gap when anyone else (or the owner alone) still requests.
            if (en && found_c) begin
              hold_cnt_q <= '0;
              gnt        <= 8'd1 << win_c;
              gnt_valid  <= 1'b1;
              gnt_id     <= win_c;
            end else begin
              state_q    <= IDLE;
              hold_cnt_q <= '0;
              gnt        <= 8'd0;
              gnt_valid  <= 1'b0;
              gnt_id     <= 3'd0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: owner/ptr reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized fairness run.
module tb_rr_arbiter8;

  localparam int unsigned MAX_HOLD = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int          BOUND    = 7 * MAX_HOLD + 7;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_id;

  int tests_run    = 0;
  int tests_failed = 0;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: who owns the grant, how many cycles it has been visible, and the next start point.
  int m_owner;
  int m_held;
  int m_ptr;

  function automatic int pick(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_held  <= 0;
      m_ptr   <= 0;
    end else if (m_owner < 0) begin
      if (en && req != 8'd0) begin
        m_owner <= pick(req, m_ptr);
        m_held  <= 1;
      end
    end else if (!req[m_owner] || m_held == int'(MAX_HOLD)) begin
      m_ptr <= (m_owner + 1) % 8;
      if (en && req != 8'd0) begin
        m_owner <= pick(req, m_owner + 1);
        m_held  <= 1;
      end else begin
        m_owner <= -1;
        m_held  <= 0;
      end
    end else begin
      m_held <= m_held + 1;
    end
  end

  logic       track;
  int         waits [8];
  int         max_wait;
  logic [7:0] exp_gnt;

  // Per-cycle comparison against the model, plus the starvation measurement.
  always @(negedge clk) begin
    exp_gnt = (m_owner < 0) ? 8'd0 : (8'd1 << m_owner);
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    check("gnt_id", 32'(gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check("onehot0", 32'($onehot0(gnt)), 32'd1);
    if (track) begin
      for (int i = 0; i < 8; i++) begin
        if (req[i] && !gnt[i]) waits[i] = waits[i] + 1;
        else waits[i] = 0;
        if (waits[i] > max_wait) max_wait = waits[i];
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string name, input logic [7:0] g, input logic [2:0] id);
    check({name, ".gnt"}, 32'(gnt), 32'(g));
    check({name, ".id"}, 32'(gnt_id), 32'(id));
    check({name, ".valid"}, 32'(gnt_valid), 32'(g != 8'd0));
  endtask

  initial begin
    track    = 1'b0;
    max_wait = 0;
    for (int i = 0; i < 8; i++) waits[i] = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'd0;
    cyc();
    cyc();
    expect_out("reset", 8'h00, 3'd0);
    rst_n = 1'b1;
    cyc();

    // Basic grant then gapless handoff.
    en  = 1'b1;
    req = 8'h05;
    cyc(); expect_out("first", 8'h01, 3'd0);
    req = 8'h04;
    cyc(); expect_out("handoff", 8'h04, 3'd2);
    req = 8'h00;
    cyc(); expect_out("idle1", 8'h00, 3'd0);

    // Hold limit: two continuous requesters alternate every MAX_HOLD cycles.
    req = 8'h03;
    for (int k = 0; k < 16; k++) begin
      cyc();
      expect_out("rotate", ((k / 4) % 2 == 1) ? 8'h02 : 8'h01, ((k / 4) % 2 == 1) ? 3'd1 : 3'd0);
    end
    req = 8'h00;
    cyc(); expect_out("idle2", 8'h00, 3'd0);

    // Wrap-around 7 -> 0 and back.
    req = 8'h81;
    cyc(); expect_out("wrap7", 8'h80, 3'd7);
    req = 8'h01;
    cyc(); expect_out("wrap0", 8'h01, 3'd0);
    req = 8'h80;
    cyc(); expect_out("to7", 8'h80, 3'd7);
    req = 8'h00;
    cyc(); expect_out("idle3", 8'h00, 3'd0);
    req = 8'h81;
    cyc(); expect_out("ptr0", 8'h01, 3'd0);
    req = 8'h00;
    cyc(); expect_out("idle4", 8'h00, 3'd0);

    // Enable gating.
    en  = 1'b0;
    req = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      cyc(); expect_out("en0", 8'h00, 3'd0);
    end
    en = 1'b1;
    cyc(); expect_out("en1", 8'h02, 3'd1);
    en = 1'b0;
    cyc(); expect_out("en0hold", 8'h02, 3'd1);
    req = 8'hFD;
    cyc(); expect_out("en0rel", 8'h00, 3'd0);
    cyc(); expect_out("en0stay", 8'h00, 3'd0);

    // Sole requester is re-granted at timeout without a gap.
    en  = 1'b1;
    req = 8'h10;
    cyc(); expect_out("g4", 8'h10, 3'd4);
    for (int k = 0; k < 6; k++) begin
      cyc(); expect_out("regrant", 8'h10, 3'd4);
    end

    // Asynchronous reset mid-grant.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    req   = 8'h00;
    #1;
    expect_out("async_rst", 8'h00, 3'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    req = 8'h10;
    cyc(); expect_out("post_rst", 8'h10, 3'd4);
    req = 8'h00;
    cyc();

    // Random traffic with enable toggling, then fairness with enable held.
    for (int k = 0; k < 2000; k++) begin
      en  = ($urandom_range(0, 3) != 0);
      req = 8'($urandom);
      cyc();
    end
    en    = 1'b1;
    req   = 8'h00;
    cyc();
    track = 1'b1;
    for (int k = 0; k < 8000; k++) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      end
      cyc();
    end
    track = 1'b0;
    check("max_wait_within_bound", 32'(max_wait <= BOUND), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
